// File: rtl/time_counters.sv
// BCD time-of-day counter (HH:MM:SS) with tick-driven timekeeping and
// a per-field set mode driven by a debounced button pulse.
module time_counters (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Tick_1Hz,
    input  logic       i_Increment,
    input  logic       i_Counters_Reset,
    input  logic       i_Counters_Enable_Increment,
    input  logic [2:0] i_Counters_Enable_Count,
    output logic [3:0] o_Sec_Ones,
    output logic [2:0] o_Sec_Tens,
    output logic [3:0] o_Min_Ones,
    output logic [2:0] o_Min_Tens,
    output logic [3:0] o_Hour_Ones,
    output logic [1:0] o_Hour_Tens,
    output logic       o_Day_Wrap
);

    logic [3:0] sec_ones_q  = '0, sec_ones_d;
    logic [2:0] sec_tens_q  = '0, sec_tens_d;
    logic [3:0] min_ones_q  = '0, min_ones_d;
    logic [2:0] min_tens_q  = '0, min_tens_d;
    logic [3:0] hour_ones_q = '0, hour_ones_d;
    logic [1:0] hour_tens_q = '0, hour_tens_d;
    logic       day_wrap_q  = 1'b0, day_wrap_d;

    logic       set_mode;
    logic       pulse;
    logic [6:0] sec_next;
    logic [6:0] min_next;
    logic [5:0] hour_next;
    logic       sec_adv, min_adv, hour_adv;
    logic       sec_wrap, min_wrap, hour_wrap;

    // Next value of a 00-59 field; 59 and any illegal code load 00.
    function automatic logic [6:0] next_60(input logic [2:0] tens, input logic [3:0] ones);
        logic [6:0] r;
        if (ones > 4'd9 || tens > 3'd5 || (tens == 3'd5 && ones == 4'd9))
            r = '0;
        else if (ones == 4'd9)
            r = {tens + 3'd1, 4'd0};
        else
            r = {tens, ones + 4'd1};
        return r;
    endfunction

    // Next value of a 00-23 field; 23 and any illegal code load 00.
    function automatic logic [5:0] next_24(input logic [1:0] tens, input logic [3:0] ones);
        logic [5:0] r;
        if (ones > 4'd9 || tens > 2'd2 || (tens == 2'd2 && ones >= 4'd3))
            r = '0;
        else if (ones == 4'd9)
            r = {tens + 2'd1, 4'd0};
        else
            r = {tens, ones + 4'd1};
        return r;
    endfunction

    always_comb begin
        set_mode  = i_Counters_Enable_Increment;
        pulse     = set_mode ? i_Increment : i_Tick_1Hz;
        sec_next  = next_60(sec_tens_q, sec_ones_q);
        min_next  = next_60(min_tens_q, min_ones_q);
        hour_next = next_24(hour_tens_q, hour_ones_q);

        // A field wraps exactly when it advances and lands on 00; carries
        // chain only in tick mode, and a held seconds field never wraps.
        sec_adv   = pulse & i_Counters_Enable_Count[0] & ~i_Counters_Reset;
        sec_wrap  = sec_adv & (sec_next == '0);
        min_adv   = pulse & i_Counters_Enable_Count[1] & (set_mode | sec_wrap);
        min_wrap  = min_adv & (min_next == '0);
        hour_adv  = pulse & i_Counters_Enable_Count[2] & (set_mode | min_wrap);
        hour_wrap = hour_adv & (hour_next == '0);

        {sec_tens_d, sec_ones_d}   = {sec_tens_q, sec_ones_q};
        {min_tens_d, min_ones_d}   = {min_tens_q, min_ones_q};
        {hour_tens_d, hour_ones_d} = {hour_tens_q, hour_ones_q};

        if (i_Counters_Reset)
            {sec_tens_d, sec_ones_d} = '0;
        else if (sec_adv)
            {sec_tens_d, sec_ones_d} = sec_next;
        if (min_adv)
            {min_tens_d, min_ones_d} = min_next;
        if (hour_adv)
            {hour_tens_d, hour_ones_d} = hour_next;

        // In tick mode an hour wrap implies minute and second wraps.
        day_wrap_d = ~set_mode & hour_wrap;
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            sec_ones_q  <= '0;
            sec_tens_q  <= '0;
            min_ones_q  <= '0;
            min_tens_q  <= '0;
            hour_ones_q <= '0;
            hour_tens_q <= '0;
            day_wrap_q  <= 1'b0;
        end else begin
            sec_ones_q  <= sec_ones_d;
            sec_tens_q  <= sec_tens_d;
            min_ones_q  <= min_ones_d;
            min_tens_q  <= min_tens_d;
            hour_ones_q <= hour_ones_d;
            hour_tens_q <= hour_tens_d;
            day_wrap_q  <= day_wrap_d;
        end
    end

    assign o_Sec_Ones  = sec_ones_q;
    assign o_Sec_Tens  = sec_tens_q;
    assign o_Min_Ones  = min_ones_q;
    assign o_Min_Tens  = min_tens_q;
    assign o_Hour_Ones = hour_ones_q;
    assign o_Hour_Tens = hour_tens_q;
    assign o_Day_Wrap  = day_wrap_q;

endmodule

// File: tb/tb_time_counters.sv
// Scoreboard bench for time_counters: the driver queues hand-computed
// expected times, a negedge monitor pops and compares them.
module tb_time_counters;

    logic       clk = 1'b0;
    logic       i_Reset = 1'b0;
    logic       i_Tick_1Hz = 1'b0;
    logic       i_Increment = 1'b0;
    logic       i_Counters_Reset = 1'b0;
    logic       i_Counters_Enable_Increment = 1'b0;
    logic [2:0] i_Counters_Enable_Count = '0;
    logic [3:0] o_Sec_Ones;
    logic [2:0] o_Sec_Tens;
    logic [3:0] o_Min_Ones;
    logic [2:0] o_Min_Tens;
    logic [3:0] o_Hour_Ones;
    logic [1:0] o_Hour_Tens;
    logic       o_Day_Wrap;

    typedef struct packed {
        logic [1:0] ht;
        logic [3:0] ho;
        logic [2:0] mt;
        logic [3:0] mo;
        logic [2:0] st;
        logic [3:0] so;
        logic       dw;
    } vec_t;

    typedef struct {
        int    due;
        vec_t  exp;
        string name;
    } entry_t;

    entry_t sb[$];
    int     cyc = 0;
    int     n_vec = 0;
    int     n_err = 0;

    time_counters dut (
        .i_Clock                     (clk),
        .i_Reset                     (i_Reset),
        .i_Tick_1Hz                  (i_Tick_1Hz),
        .i_Increment                 (i_Increment),
        .i_Counters_Reset            (i_Counters_Reset),
        .i_Counters_Enable_Increment (i_Counters_Enable_Increment),
        .i_Counters_Enable_Count     (i_Counters_Enable_Count),
        .o_Sec_Ones                  (o_Sec_Ones),
        .o_Sec_Tens                  (o_Sec_Tens),
        .o_Min_Ones                  (o_Min_Ones),
        .o_Min_Tens                  (o_Min_Tens),
        .o_Hour_Ones                 (o_Hour_Ones),
        .o_Hour_Tens                 (o_Hour_Tens),
        .o_Day_Wrap                  (o_Day_Wrap)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t tv(input int h, input int m, input int s, input bit dw);
        vec_t t;
        t.ht = 2'(h / 10);
        t.ho = 4'(h % 10);
        t.mt = 3'(m / 10);
        t.mo = 4'(m % 10);
        t.st = 3'(s / 10);
        t.so = 4'(s % 10);
        t.dw = dw;
        return t;
    endfunction

    // Monitor: registered outputs are sampled on the falling edge.
    always @(negedge clk) begin
        entry_t e;
        vec_t   got;
        got = '{ht: o_Hour_Tens, ho: o_Hour_Ones, mt: o_Min_Tens, mo: o_Min_Ones,
                st: o_Sec_Tens, so: o_Sec_Ones, dw: o_Day_Wrap};
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            n_vec++;
            if (e.due < cyc) begin
                n_err++;
                $display("FAIL %s: entry not checked at cycle %0d (now %0d)", e.name, e.due, cyc);
            end else if (got !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %0d%0d:%0d%0d:%0d%0d wrap=%0d, expected %0d%0d:%0d%0d:%0d%0d wrap=%0d",
                         e.name, got.ht, got.ho, got.mt, got.mo, got.st, got.so, got.dw,
                         e.exp.ht, e.exp.ho, e.exp.mt, e.exp.mo, e.exp.st, e.exp.so, e.exp.dw);
            end
        end
    end

    task automatic step(input logic rst, input logic tick, input logic inc, input logic crst,
                        input logic mode, input logic [2:0] en,
                        input bit chk, input vec_t exp, input string name);
        entry_t e;
        @(negedge clk);
        i_Reset                     = rst;
        i_Tick_1Hz                  = tick;
        i_Increment                 = inc;
        i_Counters_Reset            = crst;
        i_Counters_Enable_Increment = mode;
        i_Counters_Enable_Count     = en;
        if (chk) begin
            e.due  = cyc + 1;
            e.exp  = exp;
            e.name = name;
            sb.push_back(e);
        end
    endtask

    // Reach an arbitrary time by reset followed by per-field set-mode increments.
    task automatic set_time(input int h, input int m, input int s);
        step(1, 0, 0, 0, 0, 3'b000, 0, '0, "");
        for (int i = 0; i < s; i++) step(0, 0, 1, 0, 1, 3'b001, 0, '0, "");
        for (int i = 0; i < m; i++) step(0, 0, 1, 0, 1, 3'b010, 0, '0, "");
        for (int i = 0; i < h; i++) step(0, 0, 1, 0, 1, 3'b100, 0, '0, "");
        step(0, 0, 0, 0, 0, 3'b000, 1, tv(h, m, s, 0), "set_time");
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 3'b000, 1, tv(0, 0, 0, 0), "powerup");
        step(1, 0, 0, 0, 0, 3'b000, 1, tv(0, 0, 0, 0), "reset");

        set_time(23, 59, 58);
        step(0, 1, 0, 0, 0, 3'b111, 1, tv(23, 59, 59, 0), "tick_to_59");
        step(0, 1, 0, 0, 0, 3'b111, 1, tv(0, 0, 0, 1), "day_wrap");
        step(0, 0, 0, 0, 0, 3'b111, 1, tv(0, 0, 0, 0), "wrap_one_cycle");
        step(0, 1, 0, 0, 0, 3'b111, 1, tv(0, 0, 1, 0), "tick_after_wrap");
        step(0, 1, 0, 0, 0, 3'b000, 1, tv(0, 0, 1, 0), "all_disabled");

        set_time(12, 59, 30);
        step(0, 0, 1, 0, 1, 3'b010, 1, tv(12, 0, 30, 0), "set_min_no_carry");
        step(0, 1, 0, 0, 1, 3'b010, 1, tv(12, 0, 30, 0), "set_tick_ignored");
        step(0, 0, 1, 0, 0, 3'b111, 1, tv(12, 0, 30, 0), "tick_inc_ignored");

        set_time(9, 15, 0);
        step(0, 0, 1, 0, 1, 3'b100, 1, tv(10, 15, 0, 0), "set_hr_09_10");
        set_time(23, 15, 0);
        step(0, 0, 1, 0, 1, 3'b100, 1, tv(0, 15, 0, 0), "set_hr_23_00");
        set_time(23, 59, 59);
        step(0, 0, 1, 0, 1, 3'b111, 1, tv(0, 0, 0, 0), "set_all_no_daywrap");

        set_time(7, 42, 37);
        step(0, 1, 0, 1, 0, 3'b111, 1, tv(7, 42, 0, 0), "sec_clear");
        set_time(7, 42, 59);
        step(0, 1, 0, 1, 0, 3'b111, 1, tv(7, 42, 0, 0), "clear_no_carry");

        set_time(5, 59, 59);
        step(0, 1, 0, 0, 0, 3'b101, 1, tv(5, 59, 0, 0), "blocked_carry");
        set_time(5, 59, 59);
        step(0, 1, 0, 0, 0, 3'b111, 1, tv(6, 0, 0, 0), "carry_to_hour");

        set_time(14, 30, 59);
        step(1, 1, 1, 0, 0, 3'b111, 1, tv(0, 0, 0, 0), "reset_priority");
        step(0, 1, 0, 0, 0, 3'b111, 1, tv(0, 0, 1, 0), "tick_after_reset");

        step(0, 0, 0, 0, 0, 3'b000, 0, '0, "");
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
